// File: rtl/text_sequencer_pkg.sv
// Shared types and constants for the text sequencer: FSM states, message lengths, timing defaults.
// Optional skip feature is enabled by defining TEXT_SKIP_EN.
package text_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TYPE,
    HOLD,
    DONE
  } state_t;

  localparam int SEL_W = 3;
  localparam int IDX_W = 5;
  localparam int CNT_W = 8;

  localparam int CHAR_DELAY_DEF = 4;
  localparam int HOLD_TICKS_DEF = 60;

  // Characters per message, indexed by message code.
  localparam logic [IDX_W-1:0] MSG_LEN [8] = '{
    5'd0, 5'd12, 5'd9, 5'd9, 5'd14, 5'd18, 5'd10, 5'd16
  };

endpackage

// File: rtl/text_sequencer_if.sv
// Controller-side bus of the text sequencer; master drives message control, slave reveals text.
// The skip input exists only when TEXT_SKIP_EN is defined.
interface text_sequencer_if;
  import text_pkg::*;

  logic             rstText;
  logic [SEL_W-1:0] textSel;
  logic             tick;
  logic             pause;
`ifdef TEXT_SKIP_EN
  logic             skip;
`endif
  logic [7:0]       charAddr;
  logic [IDX_W-1:0] charIdx;
  logic             charWe;
  logic             textFin;

  modport master (
`ifdef TEXT_SKIP_EN
    output skip,
`endif
    output rstText, textSel, tick, pause,
    input  charAddr, charIdx, charWe, textFin
  );

  modport slave (
`ifdef TEXT_SKIP_EN
    input  skip,
`endif
    input  rstText, textSel, tick, pause,
    output charAddr, charIdx, charWe, textFin
  );

endinterface

// File: rtl/text_len_rom.sv
// Combinational length lookup: 3-bit message code to number of characters in that message.
module text_len_rom
  import text_pkg::*;
(
  input  logic [SEL_W-1:0] code,
  output logic [IDX_W-1:0] len
);

  assign len = MSG_LEN[code];

endmodule

// File: rtl/text_sequencer.sv
// Typewriter-style message reveal: latches a message code, reveals one character every CHAR_DELAY
// ticks, holds for HOLD_TICKS ticks, then flags completion. TEXT_SKIP_EN adds a skip-to-end input.
module text_sequencer
  import text_pkg::*;
#(
  parameter int CHAR_DELAY = CHAR_DELAY_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input logic             clk,
  input logic             rst,
  text_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [IDX_W-1:0] len_q,   len_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] tick_q,  tick_d;
  logic [CNT_W-1:0] hold_q,  hold_d;
  logic             we_q,    we_d;

  logic [IDX_W-1:0] rom_len;
  logic [IDX_W-1:0] idx_inc;
  logic             qual_tick;
  logic             skip_go;

  text_len_rom u_len_rom (
    .code (sel_q),
    .len  (rom_len)
  );

  assign idx_inc   = idx_q + 5'd1;
  assign qual_tick = bus.tick && !bus.pause;

`ifdef TEXT_SKIP_EN
  assign skip_go = bus.skip && !bus.pause;
`else
  assign skip_go = 1'b0;
`endif

  // NOTE: every next-state variable takes its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    we_d    = 1'b0;

    if (bus.rstText) begin
      state_d = IDLE;
      idx_d   = '0;
      tick_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = LOAD;
          sel_d   = bus.textSel;
        end

        LOAD: begin
          len_d   = rom_len;
          idx_d   = '0;
          tick_d  = '0;
          hold_d  = '0;
          state_d = (rom_len == '0) ? HOLD : TYPE;
        end

        TYPE: begin
          if (skip_go) begin
            idx_d   = len_q;
            we_d    = 1'b1;
            tick_d  = '0;
            state_d = HOLD;
          end else if (qual_tick) begin
            if (tick_q == CHAR_LAST) begin
              tick_d = '0;
              idx_d  = idx_inc;
              we_d   = 1'b1;
              if (idx_inc == len_q) state_d = HOLD;
            end else begin
              tick_d = tick_q + 8'd1;
            end
          end
        end

        HOLD: begin
          if (skip_go) begin
            state_d = DONE;
          end else if (HOLD_TICKS == 0) begin
            // A zero hold still spends one (unpaused) cycle here before finishing.
            if (!bus.pause) state_d = DONE;
          end else if (qual_tick) begin
            hold_d = hold_q + 8'd1;
            if (hold_q == HOLD_LAST) state_d = DONE;
          end
        end

        DONE: ;

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
    end
  end

  assign bus.charAddr = {sel_q, idx_q};
  assign bus.charIdx  = idx_q;
  assign bus.charWe   = we_q;
  assign bus.textFin  = (state_q == DONE);

endmodule

// File: doc/text_sequencer.md
TEXT_SEQUENCER -- requirements
Module: text_sequencer

Interface
REQ-001 Parameter CHAR_DELAY, default 4, number of tick pulses between successive character reveals (legal 1..255).
REQ-002 Parameter HOLD_TICKS, default 60, number of tick pulses the complete message stays on screen before finish (legal 0..255).
REQ-003 Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- rstText  in  1  message clear/hold-off from the game controller.
- textSel  in  3  message code {text2,text1,text0}.
- tick  in  1  one-cycle timebase enable.
- pause  in  1  freeze timing.
- charAddr  out  8  message ROM address {selReg, charIdx}.
- charIdx  out  5  count of characters revealed so far.
- charWe  out  1  one-cycle strobe per revealed character.
- textFin  out  1  message complete.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, TYPE, HOLD and DONE.
REQ-005 IDLE SHALL move to LOAD on the first cycle with rstText=0, and SHALL latch textSel into selReg on that edge.
REQ-006 LOAD SHALL last exactly one cycle, capture msgLen from the length ROM, and move to TYPE; if msgLen=0 it SHALL move to HOLD instead.
REQ-007 In TYPE, a tick counter SHALL advance on each cycle with tick=1 and pause=0.
REQ-008 In TYPE, on the tick that brings the counter to CHAR_DELAY, the block SHALL clear the counter, increment charIdx, and pulse charWe for one cycle (the charWe cycle is the cycle after that tick).
REQ-009 When charIdx reaches msgLen, the FSM SHALL enter HOLD with the tick counter cleared; charIdx SHALL never exceed msgLen (maximum 31).
REQ-010 HOLD SHALL count HOLD_TICKS qualified ticks, then enter DONE; if HOLD_TICKS=0, HOLD SHALL last exactly one cycle.
REQ-011 DONE SHALL hold textFin=1 and freeze all counters until rstText=1.
REQ-012 rstText=1 in any state SHALL force IDLE on the next edge and clear charIdx, the counters, charWe and textFin; this takes priority over tick and pause.
REQ-013 After LOAD, changes on textSel SHALL be ignored until the next IDLE exit.
REQ-014 pause=1 SHALL freeze state, counters and charIdx; charWe SHALL NOT pulse while paused.
REQ-015 charAddr SHALL equal {selReg, charIdx} combinationally from registers.
REQ-016 Message lengths SHALL be: code0=0, 1=12, 2=9, 3=9, 4=14, 5=18, 6=10, 7=16.

Reset
REQ-017 rst=1 SHALL force IDLE and set selReg=0, charIdx=0, charAddr=0, charWe=0, textFin=0, and both counters to 0.
REQ-018 rst SHALL take priority over rstText, pause and skip.

Configuration
REQ-019 Macro TEXT_SKIP_EN.
- Defined: adds input skip (1 bit).
- skip=1 in TYPE sets charIdx=msgLen, pulses charWe once, and enters HOLD.
- skip=1 in HOLD enters DONE on the next edge.
- skip is ignored in IDLE, LOAD and DONE, and while pause=1.
- Undefined: no skip port; behaviour is exactly as specified in REQ-004 to REQ-016.

Structure
REQ-020 Package text_pkg SHALL hold the state enum, the MSG_LEN constant array, and the CHAR_DELAY and HOLD_TICKS defaults.
REQ-021 Sub-module text_len_rom SHALL map the 3-bit message code to a 5-bit length, combinationally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Scenario 1: rst; textSel=1; rstText falls; tick every cycle.
  - Response: 12 charWe pulses, spaced 4 cycles apart; charIdx ends at 12; textFin rises after 60 further ticks.
- Scenario 2: textSel=0.
  - Response: no charWe; textFin rises after LOAD + 60 ticks.
- Scenario 3: pause held high for 20 cycles after the 3rd charWe.
  - Response: charIdx stays 3; charWe resumes 4 ticks after pause falls.
- Scenario 4: textSel changes 1->5 in the middle of TYPE.
  - Response: charAddr upper bits stay 1; total reveals = 12.
- Scenario 5: rstText pulses in HOLD, then again in DONE.
  - Response: the next cycle is IDLE with charIdx=0 and textFin=0; the message restarts with a new textSel latch.
- Scenario 6 (TEXT_SKIP_EN): skip at charIdx=2 of message 4.
  - Response: one charWe; charIdx=14; HOLD. A second skip gives DONE next cycle.
